ahb_soc_3_slaves: RTL and testbench
===================================

Name: ahb_soc_3_slaves

Overview:
- Self-contained AHB-Lite subsystem for bring-up and simulation.
- Contains an internal scripted bus master (traffic sequencer), an address decoder, three identical zero-wait-state SRAM slaves and a read-data/response mux.
- After reset, the master writes a known pattern into every slave, reads it back and reports pass/fail.
- No external bus. Only clock, reset and status pins leave the block.

Parameters:
- NWORDS, 8, words exercised per slave; also the SRAM depth. Power of two, 2..256.
- PATTERN, 32'hA5A5_0000, base of the write data pattern.

Ports:
- HCLK  input  1  system clock; all logic on rising edge.
- HRESET  input  1  asynchronous, active-high reset; clears all sequencer and bus-control state.
- done  output  1  high once the full write/read-back script has completed; sticky until reset.
- pass  output  1  valid when done=1: 1 means zero mismatches.
- err_cnt  output  8  number of read-back mismatches, saturating at 255.

Behaviour:
- Bus protocol:
  - 32-bit AHB-Lite.
  - HSIZE is always word (3'b010). HBURST is always SINGLE.
  - HTRANS is NONSEQ (2'b10) for active transfers, otherwise IDLE (2'b00).
  - HREADY is always 1 (no wait states). HRESP is always OKAY.
- Address map, decoded on HADDR[31:24]:
  - 8'h00 selects slave0.
  - 8'h20 selects slave1.
  - 8'h40 selects slave2.
  - Any other value selects the default slave: HRDATA=0, write ignored.
  - Word index is HADDR[log2(NWORDS)+1:2].
- Slave:
  - Registers HSEL, HWRITE, HTRANS[1] and the word index in the address phase.
  - Writes HWDATA into its memory at the end of the data phase.
  - Read data is driven combinationally during the data phase from the registered index.
  - Memory contents are not reset.
- Read mux: selects HRDATA using the slave select registered in the address phase.
- Sequencer FSM states: WRITE, READ, DONE.
  - Reset value is WRITE with index 0. done=0, pass=0, err_cnt=0.
  - Cycle 0 is the first HCLK rising edge after HRESET falls. Address phases run back to back, one per cycle.
  - WRITE covers cycles 0..3*NWORDS-1.
    - Slave s = 0,1,2 in order; word k = 0..NWORDS-1 within each slave.
    - HADDR = base_s + 4*k.
    - HWDATA in the following cycle = PATTERN | (s<<8) | k.
  - READ covers the same address order, cycles 3*NWORDS..6*NWORDS-1, with HWRITE=0.
    - In each read data phase, HRDATA is compared with the expected value.
    - On a mismatch, err_cnt increments (saturating at 255).
  - The last read data phase is cycle 6*NWORDS. DONE is entered at the end of that cycle, so done=1 from cycle 6*NWORDS+1 onward.
  - In DONE, HTRANS=IDLE. pass = (err_cnt==0). Outputs hold until reset.
- The write of the final word and the first read address phase overlap legally, because the write targets a different word.
- Reset mid-script: all control state clears immediately (asynchronous). The script restarts from cycle 0 on the first edge after release, and memory is rewritten.

Decomposition:
- Shared package contains:
  - AHB constants: HTRANS_IDLE, HTRANS_NONSEQ, HSIZE_WORD, HRESP_OKAY.
  - Slave base addresses: 8'h00, 8'h20, 8'h40.
  - The expected-data function: PATTERN | (s<<8) | k.
- One natural sub-module, ahb_sram_slave (parameter NWORDS), instantiated three times.
- Sequencer, decoder and mux stay in the top level.

Test Plan:
- Reset hold: assert HRESET for 47 ns with a 10 ns HCLK -> done=0, pass=0, err_cnt=0, HTRANS=IDLE throughout.
- Nominal run with NWORDS=8: release reset -> done rises exactly 49 cycles after the first post-reset edge, with pass=1 and err_cnt=0.
- Bus content check: during WRITE, the probed HADDR/HWDATA sequence begins 0x00000000/0xA5A50000 and 0x00000004/0xA5A50001. The first slave1 write is 0x20000000/0xA5A50100, and the last write is 0x4000001C/0xA5A50207.
- Decode check: after done, slave1 memory word 3 equals 0xA5A50103, and slave0 word 3 equals 0xA5A50003, confirming no aliasing.
- Mismatch detection: force slave2 word 5 to 0xDEADBEEF during READ, before its data phase -> done=1, pass=0, err_cnt=1.
- Reset mid-operation: pulse HRESET at cycle 20 -> outputs clear asynchronously. After release the script restarts, and done rises 49 cycles after the first post-release edge with pass=1.

Source files
------------

// File: rtl/ahb_soc_3_slaves_pkg.sv
// Shared AHB-Lite constants, slave map and the scripted write/read-back data pattern.
package ahb_soc_3_slaves_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic       HRESP_OKAY    = 1'b0;

    localparam logic [7:0] SLAVE0_BASE = 8'h00;
    localparam logic [7:0] SLAVE1_BASE = 8'h20;
    localparam logic [7:0] SLAVE2_BASE = 8'h40;

    typedef enum logic [1:0] {
        ST_WRITE = 2'd0,
        ST_READ  = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_t;

    // Index 3 is the sequencer's drain slot; it maps outside every slave.
    function automatic logic [7:0] slave_base(input logic [1:0] s);
        case (s)
            2'd0:    return SLAVE0_BASE;
            2'd1:    return SLAVE1_BASE;
            2'd2:    return SLAVE2_BASE;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] pattern,
                                             input logic [1:0]  s,
                                             input logic [7:0]  k);
        return pattern | {22'd0, s, 8'd0} | {24'd0, k};
    endfunction

endpackage

// File: rtl/ahb_sram_slave.sv
// Zero-wait-state AHB-Lite SRAM slave: registered address phase, write at end of data phase.
module ahb_sram_slave
    import ahb_soc_3_slaves_pkg::*;
#(
    parameter int unsigned NWORDS = 8
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic                      hsel,
    input  logic                      hwrite,
    input  logic [1:0]                htrans,
    input  logic [$clog2(NWORDS)-1:0] hidx,
    input  logic [31:0]               hwdata,
    output logic [31:0]               hrdata,
    output logic                      hreadyout,
    output logic                      hresp
);

    localparam int unsigned AW = $clog2(NWORDS);

    logic          sel_q;
    logic          write_q;
    logic          trans_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   mem [NWORDS];
    logic          unused_trans;

    assign unused_trans = htrans[0];

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            sel_q   <= 1'b0;
            write_q <= 1'b0;
            trans_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            sel_q   <= hsel;
            write_q <= hwrite;
            trans_q <= htrans[1];
            idx_q   <= hidx;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge hclk) begin
        if (sel_q && write_q && trans_q) begin
            mem[idx_q] <= hwdata;
        end
    end

    assign hrdata    = mem[idx_q];
    assign hreadyout = 1'b1;
    assign hresp     = HRESP_OKAY;

endmodule

// File: rtl/ahb_soc_3_slaves.sv
// Self-testing AHB-Lite subsystem: scripted master writes a pattern to three SRAMs and reads it back.
module ahb_soc_3_slaves
    import ahb_soc_3_slaves_pkg::*;
#(
    parameter int unsigned NWORDS  = 8,
    parameter logic [31:0] PATTERN = 32'hA5A5_0000
) (
    input  logic       HCLK,
    input  logic       HRESET,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt
);

    localparam int unsigned AW     = $clog2(NWORDS);
    localparam logic [AW-1:0] LAST_K = AW'(NWORDS - 1);

    seq_state_t    state, state_n;
    logic          started, started_n;
    logic [1:0]    sel_s, sel_s_n;
    logic [AW-1:0] word_k, word_k_n;
    logic          done_n, pass_n;
    logic [7:0]    err_cnt_n;

    logic          addr_valid;
    logic [31:0]   haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [31:0]   hwdata;
    logic [31:0]   hrdata;
    logic          hready;
    logic          hresp;
    logic          mismatch;

    logic          dp_write, dp_read;
    logic [1:0]    dp_s;
    logic [AW-1:0] dp_k;
    logic [1:0]    dec_idx, dsel_q;
    logic [2:0]    hsel;

    logic [31:0]   rdata_s [3];
    logic          ready_s [3];
    logic          resp_s  [3];
    logic          unused_bus;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= ST_WRITE;
            started  <= 1'b0;
            sel_s    <= '0;
            word_k   <= '0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            dp_write <= 1'b0;
            dp_read  <= 1'b0;
            dp_s     <= '0;
            dp_k     <= '0;
            dsel_q   <= 2'd3;
        end else begin
            state    <= state_n;
            started  <= started_n;
            sel_s    <= sel_s_n;
            word_k   <= word_k_n;
            done     <= done_n;
            pass     <= pass_n;
            err_cnt  <= err_cnt_n;
            dp_write <= addr_valid && hwrite;
            dp_read  <= addr_valid && !hwrite;
            dp_s     <= sel_s;
            dp_k     <= word_k;
            dsel_q   <= dec_idx;
        end
    end

    // Sequencer: sel_s==3 in READ is the drain cycle carrying the last read data phase.
    always_comb begin
        state_n    = state;
        started_n  = 1'b1;
        sel_s_n    = sel_s;
        word_k_n   = word_k;
        addr_valid = started && ((state == ST_WRITE) || (state == ST_READ && sel_s != 2'd3));
        if (started) begin
            case (state)
                ST_WRITE: begin
                    if (word_k == LAST_K) begin
                        word_k_n = '0;
                        if (sel_s == 2'd2) begin
                            sel_s_n = '0;
                            state_n = ST_READ;
                        end else begin
                            sel_s_n = sel_s + 2'd1;
                        end
                    end else begin
                        word_k_n = word_k + AW'(1);
                    end
                end
                ST_READ: begin
                    if (sel_s == 2'd3) begin
                        state_n = ST_DONE;
                    end else if (word_k == LAST_K) begin
                        word_k_n = '0;
                        sel_s_n  = sel_s + 2'd1;
                    end else begin
                        word_k_n = word_k + AW'(1);
                    end
                end
                default: state_n = ST_DONE;
            endcase
        end

        mismatch  = dp_read && (hrdata != exp_data(PATTERN, dp_s, 8'(dp_k)));
        err_cnt_n = (mismatch && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
        done_n    = done || (state_n == ST_DONE);
        pass_n    = done_n && (err_cnt_n == 8'd0);
    end

    assign htrans = addr_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign hwrite = addr_valid && (state == ST_WRITE);
    assign hsize  = HSIZE_WORD;
    assign hburst = HBURST_SINGLE;
    assign haddr  = {slave_base(sel_s), {(22 - AW){1'b0}}, word_k, 2'b00};
    assign hwdata = dp_write ? exp_data(PATTERN, dp_s, 8'(dp_k)) : 32'd0;

    // Address decoder; index 3 is the default slave.
    always_comb begin
        case (haddr[31:24])
            SLAVE0_BASE: dec_idx = 2'd0;
            SLAVE1_BASE: dec_idx = 2'd1;
            SLAVE2_BASE: dec_idx = 2'd2;
            default:     dec_idx = 2'd3;
        endcase
        hsel = 3'b000;
        if (dec_idx != 2'd3) hsel[dec_idx] = 1'b1;
    end

    ahb_sram_slave #(.NWORDS(NWORDS)) u_slave0 (
        .hclk(HCLK), .hreset(HRESET), .hsel(hsel[0]), .hwrite(hwrite), .htrans(htrans),
        .hidx(haddr[AW+1:2]), .hwdata(hwdata), .hrdata(rdata_s[0]),
        .hreadyout(ready_s[0]), .hresp(resp_s[0])
    );

    ahb_sram_slave #(.NWORDS(NWORDS)) u_slave1 (
        .hclk(HCLK), .hreset(HRESET), .hsel(hsel[1]), .hwrite(hwrite), .htrans(htrans),
        .hidx(haddr[AW+1:2]), .hwdata(hwdata), .hrdata(rdata_s[1]),
        .hreadyout(ready_s[1]), .hresp(resp_s[1])
    );

    ahb_sram_slave #(.NWORDS(NWORDS)) u_slave2 (
        .hclk(HCLK), .hreset(HRESET), .hsel(hsel[2]), .hwrite(hwrite), .htrans(htrans),
        .hidx(haddr[AW+1:2]), .hwdata(hwdata), .hrdata(rdata_s[2]),
        .hreadyout(ready_s[2]), .hresp(resp_s[2])
    );

    // Data-phase mux driven by the select captured in the address phase.
    always_comb begin
        hrdata = 32'd0;
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        if (dsel_q != 2'd3) begin
            hrdata = rdata_s[dsel_q];
            hready = ready_s[dsel_q];
            hresp  = resp_s[dsel_q];
        end
    end

    // Fixed-size single-beat master: these bus fields never steer logic here.
    assign unused_bus = ^{haddr[23:AW+2], haddr[1:0], hsize, hburst, hready, hresp};

endmodule

// File: tb/tb_ahb_soc_3_slaves.sv
// Directed bench: nominal script, bus probes, decode, forced mismatch, async reset and restart.
module tb_ahb_soc_3_slaves;
    import ahb_soc_3_slaves_pkg::*;

    logic       HCLK;
    logic       HRESET;
    logic       done;
    logic       pass;
    logic [7:0] err_cnt;

    int total;
    int bad;
    int cyc;

    ahb_soc_3_slaves #(.NWORDS(8), .PATTERN(32'hA5A5_0000)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .done(done), .pass(pass), .err_cnt(err_cnt)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
        cyc++;
    endtask

    task automatic run_to_done(input string tag);
        while (done !== 1'b1 && cyc < 200) tick();
        chk(tag, 32'(cyc), 32'd49);
    endtask

    task automatic release_reset();
        @(negedge HCLK);
        HRESET = 1'b0;
        cyc = -1;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        cyc    = -1;
        HRESET = 1'b1;

        // Reset hold for 47 ns
        #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_htrans", 32'(dut.htrans), 32'(HTRANS_IDLE));
        repeat (4) begin
            @(negedge HCLK);
            chk("rst_hold_done", 32'(done), 32'd0);
            chk("rst_hold_htrans", 32'(dut.htrans), 32'(HTRANS_IDLE));
        end
        #7;
        HRESET = 1'b0;

        // Nominal run with bus probes
        tick();
        chk("c0_haddr", dut.haddr, 32'h0000_0000);
        chk("c0_htrans", 32'(dut.htrans), 32'(HTRANS_NONSEQ));
        chk("c0_hwrite", 32'(dut.hwrite), 32'd1);
        tick();
        chk("c1_haddr", dut.haddr, 32'h0000_0004);
        chk("c1_hwdata", dut.hwdata, 32'hA5A5_0000);
        tick();
        chk("c2_hwdata", dut.hwdata, 32'hA5A5_0001);
        while (cyc < 8) tick();
        chk("s1_first_haddr", dut.haddr, 32'h2000_0000);
        tick();
        chk("s1_first_hwdata", dut.hwdata, 32'hA5A5_0100);
        while (cyc < 23) tick();
        chk("last_wr_haddr", dut.haddr, 32'h4000_001C);
        tick();
        chk("last_wr_hwdata", dut.hwdata, 32'hA5A5_0207);
        chk("first_rd_hwrite", 32'(dut.hwrite), 32'd0);
        chk("first_rd_haddr", dut.haddr, 32'h0000_0000);
        chk("first_rd_htrans", 32'(dut.htrans), 32'(HTRANS_NONSEQ));
        chk("mid_done", 32'(done), 32'd0);
        run_to_done("nominal_done_cycle");
        chk("nominal_pass", 32'(pass), 32'd1);
        chk("nominal_err", 32'(err_cnt), 32'd0);
        chk("done_htrans", 32'(dut.htrans), 32'(HTRANS_IDLE));
        chk("s1_word3", dut.u_slave1.mem[3], 32'hA5A5_0103);
        chk("s0_word3", dut.u_slave0.mem[3], 32'hA5A5_0003);
        chk("s2_word7", dut.u_slave2.mem[7], 32'hA5A5_0207);
        tick();
        chk("done_sticky", 32'(done), 32'd1);

        // Async clear of a completed run, then forced mismatch
        HRESET = 1'b1;
        #1;
        chk("aclr_done", 32'(done), 32'd0);
        chk("aclr_pass", 32'(pass), 32'd0);
        release_reset();
        while (cyc < 30) tick();
        dut.u_slave2.mem[5] = 32'hDEADBEEF;
        run_to_done("mismatch_done_cycle");
        chk("mismatch_pass", 32'(pass), 32'd0);
        chk("mismatch_err", 32'(err_cnt), 32'd1);

        // Clear the error count asynchronously, then reset mid-script at cycle 20
        HRESET = 1'b1;
        #1;
        chk("aclr_err", 32'(err_cnt), 32'd0);
        release_reset();
        while (cyc < 20) tick();
        chk("pre_pulse_word_k", 32'(dut.word_k), 32'd4);
        HRESET = 1'b1;
        #1;
        chk("pulse_htrans", 32'(dut.htrans), 32'(HTRANS_IDLE));
        chk("pulse_sel_s", 32'(dut.sel_s), 32'd0);
        chk("pulse_word_k", 32'(dut.word_k), 32'd0);
        chk("pulse_done", 32'(done), 32'd0);
        release_reset();
        run_to_done("restart_done_cycle");
        chk("restart_pass", 32'(pass), 32'd1);
        chk("restart_err", 32'(err_cnt), 32'd0);
        chk("restart_s2_word5", dut.u_slave2.mem[5], 32'hA5A5_0205);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
